// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller shared by an instruction-fetch port and a load/store port.
// Build option `MEM_FIRST_EN: simultaneous requests always go to the load/store port.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_done,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    output logic [1:0]  halt_type
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_e;

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [2:0]  len_q;
    logic        owner_q;      // 1 = load/store port owns the transfer
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] buf_q;

    logic [31:0] ram_a_q;
    logic [7:0]  ram_dout_q;
    logic        ram_wr_q;
    logic [31:0] if_data_q;
    logic [31:0] mem_rdata_q;
    logic        if_done_q;
    logic        mem_done_q;

    logic        grant_if;
    logic        grant_mem;
    logic [2:0]  cnt_d;
    logic [31:0] beat_addr;
    logic [1:0]  cap_idx;

    function automatic logic [2:0] len_of(input logic [1:0] size);
        case (size)
            2'b00:   len_of = 3'd1;
            2'b01:   len_of = 3'd2;
            default: len_of = 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        byte_sel = word[{idx, 3'b000} +: 8];
    endfunction

`ifdef MEM_FIRST_EN
    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if (mem_req) begin
            grant_mem = 1'b1;
        end else if (if_req) begin
            grant_if = 1'b1;
        end
    end
`else
    logic last_mem_q;      // 1 when the load/store port was served most recently

    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if (if_req && mem_req) begin
            if (last_mem_q) begin
                grant_if = 1'b1;
            end else begin
                grant_mem = 1'b1;
            end
        end else if (if_req) begin
            grant_if = 1'b1;
        end else if (mem_req) begin
            grant_mem = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_mem_q <= 1'b1;
        end else if (state_q == IDLE && (grant_if || grant_mem)) begin
            last_mem_q <= grant_mem;
        end
    end
`endif

    assign cnt_d     = cnt_q + 3'd1;
    assign beat_addr = addr_q + {29'd0, cnt_d};
    // cnt_q runs 1..4 while bytes arrive; the low bits minus one give the byte lane
    assign cap_idx   = cnt_q[1:0] - 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            len_q       <= 3'd0;
            owner_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            ram_a_q     <= 32'd0;
            ram_dout_q  <= 8'd0;
            ram_wr_q    <= 1'b0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ram_a_q    <= 32'd0;
                    ram_dout_q <= 8'd0;
                    ram_wr_q   <= 1'b0;
                    if (grant_if || grant_mem) begin
                        owner_q <= grant_mem;
                        cnt_q   <= 3'd0;
                        buf_q   <= 32'd0;
                        wdata_q <= mem_wdata;
                        addr_q  <= grant_mem ? mem_addr : if_addr;
                        len_q   <= grant_mem ? len_of(mem_size) : 3'd4;
                        ram_a_q <= grant_mem ? mem_addr : if_addr;
                        if (grant_mem && mem_we) begin
                            state_q    <= WRITE;
                            ram_wr_q   <= 1'b1;
                            ram_dout_q <= mem_wdata[7:0];
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    cnt_q      <= cnt_d;
                    ram_wr_q   <= 1'b0;
                    ram_dout_q <= 8'd0;
                    ram_a_q    <= (cnt_d < len_q) ? beat_addr : 32'd0;
                    // RAM answers one cycle after the address, so byte k lands a cycle later
                    if (cnt_q != 3'd0 && cnt_q <= len_q) begin
                        buf_q[{cap_idx, 3'b000} +: 8] <= ram_din;
                    end
                    if (cnt_q == len_q + 3'd1) begin
                        state_q <= DONE;
                        if (owner_q) begin
                            mem_rdata_q <= buf_q;
                            mem_done_q  <= 1'b1;
                        end else begin
                            if_data_q <= buf_q;
                            if_done_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    cnt_q <= cnt_d;
                    if (cnt_d < len_q) begin
                        ram_a_q    <= beat_addr;
                        ram_wr_q   <= 1'b1;
                        ram_dout_q <= byte_sel(wdata_q, cnt_d[1:0]);
                    end else begin
                        ram_a_q    <= 32'd0;
                        ram_wr_q   <= 1'b0;
                        ram_dout_q <= 8'd0;
                    end
                    if (cnt_q == len_q) begin
                        state_q    <= DONE;
                        mem_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    // mandatory idle cycle: requests are not sampled on the way out of DONE
                    if_done_q  <= 1'b0;
                    mem_done_q <= 1'b0;
                    ram_a_q    <= 32'd0;
                    ram_dout_q <= 8'd0;
                    ram_wr_q   <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign if_data   = if_data_q;
    assign if_done   = if_done_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_done  = mem_done_q;
    assign ram_a     = ram_a_q;
    assign ram_dout  = ram_dout_q;
    assign ram_wr    = ram_wr_q;

    assign halt_type = (mem_req && !mem_done_q) ? 2'b11 :
                       (if_req && !if_done_q)   ? 2'b01 : 2'b00;

endmodule
